main_memory: RTL

//  Backing-store model and controller directly downstream of the cache control FSM.
//  - Consumes the MStrobe/MRW/address/data memory request issued by the cache controller.
//  - Holds the request for a fixed wait-state latency, commits writes and returns read data.
//  - Pulses MReady on completion; the cache's own wait-state counter stays aligned to WAIT_CYCLES.

---
 rtl/mem_pkg.sv | 23 ++
 rtl/mem_if.sv | 34 +++
 rtl/mem_wait_ctr.sv | 33 +++
 rtl/main_memory.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared types and constants for the main_memory backing-store controller.
//   mem_state_t     : controller FSM states (IDLE -> BUSY -> DONE -> IDLE)
//   DEF_*           : default geometry and wait-state latency
//   MRW_READ/WRITE  : encoding of the MRW request bit
// ---------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_BUSY,
        MEM_DONE
    } mem_state_t;

    localparam int DEF_ADDR_W      = 8;
    localparam int DEF_DATA_W      = 32;
    localparam int DEF_WAIT_CYCLES = 4;

    localparam logic MRW_READ  = 1'b0;
    localparam logic MRW_WRITE = 1'b1;

endpackage

// File: rtl/mem_if.sv
// ---------------------------------------------------------------------------
// mem_if
// Memory request bus between the cache controller (master) and main_memory
// (slave).
//   MStrobe  : request valid (master -> slave)
//   MRW      : 1 = write, 0 = read (master -> slave)
//   MAddr    : word address (master -> slave)
//   MDataIn  : write data (master -> slave)
//   MDataOut : read data, held until the next read completion (slave -> master)
//   MReady   : one-cycle completion pulse (slave -> master)
//   MBusy    : access in progress, new requests ignored (slave -> master)
// ---------------------------------------------------------------------------
interface mem_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              MStrobe;
    logic              MRW;
    logic [ADDR_W-1:0] MAddr;
    logic [DATA_W-1:0] MDataIn;
    logic [DATA_W-1:0] MDataOut;
    logic              MReady;
    logic              MBusy;

    modport master (
        output MStrobe, MRW, MAddr, MDataIn,
        input  MDataOut, MReady, MBusy
    );

    modport slave (
        input  MStrobe, MRW, MAddr, MDataIn,
        output MDataOut, MReady, MBusy
    );
endinterface

// File: rtl/mem_wait_ctr.sv
// ---------------------------------------------------------------------------
// mem_wait_ctr
// 8-bit wait-state down-counter. A load takes priority over a decrement; the
// counter saturates at zero.
//   clk      : clock
//   reset    : asynchronous, active-low reset (counter cleared)
//   load     : load load_val
//   load_val : value loaded on load
//   dec      : decrement by one (ignored at zero)
//   zero     : counter currently equals zero
// ---------------------------------------------------------------------------
module mem_wait_ctr (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       dec,
    output logic       zero
);
    logic [7:0] cnt_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg <= 8'd0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (dec && (cnt_reg != 8'd0)) begin
            cnt_reg <= cnt_reg - 8'd1;
        end
    end

    assign zero = (cnt_reg == 8'd0);
endmodule

// File: rtl/main_memory.sv
// ---------------------------------------------------------------------------
// main_memory
// Backing store behind the cache controller. A request is latched in IDLE,
// held for WAIT_CYCLES BUSY cycles, committed/read on the BUSY->DONE edge and
// acknowledged with a one-cycle MReady pulse in DONE.
//   clk      : clock, all state changes on posedge
//   reset    : asynchronous, active-low reset (array contents are kept)
//   bus      : mem_if slave modport (MStrobe/MRW/MAddr/MDataIn in,
//              MDataOut/MReady/MBusy out)
//   RdCount  : completed reads, wrapping 16-bit   (only with MEM_STATS_EN)
//   WrCount  : completed writes, wrapping 16-bit  (only with MEM_STATS_EN)
// Optional feature macro: MEM_STATS_EN (access statistics counters).
// ---------------------------------------------------------------------------
module main_memory
    import mem_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
`ifdef MEM_STATS_EN
    output logic [15:0] RdCount,
    output logic [15:0] WrCount,
`endif
    mem_if.slave        bus
);
    generate
        if ((WAIT_CYCLES < 1) || (WAIT_CYCLES > 255)) begin : g_bad_wait
            $error("main_memory: WAIT_CYCLES must be within 1..255");
        end
    endgenerate

    // The counter is loaded with WAIT_CYCLES-1 so that BUSY spans exactly
    // WAIT_CYCLES cycles including the cycle in which it reaches zero.
    localparam logic [7:0] WAIT_LOAD = 8'(WAIT_CYCLES - 1);

    mem_state_t        state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic              rw_reg;
    logic [DATA_W-1:0] data_out_reg;
    logic [DATA_W-1:0] mem_array [2**ADDR_W];

    logic accept;
    logic finish;
    logic wait_zero;

    assign accept = (state_reg == MEM_IDLE) && bus.MStrobe;
    assign finish = (state_reg == MEM_BUSY) && wait_zero;

    mem_wait_ctr u_wait_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (accept),
        .load_val (WAIT_LOAD),
        .dec      (state_reg == MEM_BUSY),
        .zero     (wait_zero)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= MEM_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            MEM_IDLE: if (bus.MStrobe) state_next = MEM_BUSY;
            MEM_BUSY: if (wait_zero)   state_next = MEM_DONE;
            MEM_DONE: state_next = MEM_IDLE;
            default:  state_next = MEM_IDLE;
        endcase
    end

    // Outputs decoded from the state register so that reset clears them at once
    always_comb begin
        bus.MReady = 1'b0;
        bus.MBusy  = 1'b0;
        case (state_reg)
            MEM_BUSY: bus.MBusy = 1'b1;
            MEM_DONE: begin
                bus.MBusy  = 1'b1;
                bus.MReady = 1'b1;
            end
            default: ;
        endcase
    end

    // Request latch and read-data register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_reg     <= '0;
            wdata_reg    <= '0;
            rw_reg       <= MRW_READ;
            data_out_reg <= '0;
        end else begin
            if (accept) begin
                addr_reg  <= bus.MAddr;
                wdata_reg <= bus.MDataIn;
                rw_reg    <= bus.MRW;
            end
            if (finish && (rw_reg == MRW_READ)) begin
                data_out_reg <= mem_array[addr_reg];
            end
        end
    end

    // Array write port. finish cannot be true while reset is held (the FSM
    // sits in IDLE), so an aborted write never reaches the array.
    always_ff @(posedge clk) begin
        if (finish && (rw_reg == MRW_WRITE)) begin
            mem_array[addr_reg] <= wdata_reg;
        end
    end

    assign bus.MDataOut = data_out_reg;

`ifdef MEM_STATS_EN
    logic [15:0] rd_count_reg;
    logic [15:0] wr_count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_count_reg <= 16'd0;
            wr_count_reg <= 16'd0;
        end else if (state_reg == MEM_DONE) begin
            if (rw_reg == MRW_WRITE) begin
                wr_count_reg <= wr_count_reg + 16'd1;
            end else begin
                rd_count_reg <= rd_count_reg + 16'd1;
            end
        end
    end

    assign RdCount = rd_count_reg;
    assign WrCount = wr_count_reg;
`endif

endmodule
